c4_move_engine: RTL and testbench

//  Connect-four game controller that sits directly upstream of the ws2812 framebuffer core inside fourConnect.

---
 rtl/c4_pkg.sv | 26 ++
 rtl/c4_debounce.sv | 44 ++++
 rtl/c4_move_engine.sv | 132 +++++++++++++
 tb/tb_c4_move_engine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared constants, FSM state type and colour helper for the connect-four controller.
package c4_pkg;

  localparam logic [23:0] C_OFF = 24'h000000;
  localparam logic [23:0] C_RED = 24'hFF0000;
  localparam logic [23:0] C_YEL = 24'hFFFF00;

  localparam int BOARD_COLS  = 6;
  localparam int BOARD_ROWS  = 6;
  localparam int MATRIX_LEDS = 64;

  localparam logic [6:0] IND_LED = 7'd63;

  typedef enum logic [2:0] {
    CLEAR,
    IND,
    IDLE,
    DROP,
    OVER
  } state_e;

  function automatic logic [23:0] player_color(input logic p);
    return p ? C_YEL : C_RED;
  endfunction

endpackage

// File: rtl/c4_debounce.sv
// Button conditioner: 2-FF synchroniser, symmetric stability counter, and a
// one-cycle pulse on each accepted press (debounced high-to-low transition).
module c4_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      press_q <= 1'b0;
      // The count only advances while the synced level disagrees with the
      // accepted level, so any bounce back restarts it from zero.
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/c4_move_engine.sv
// Connect-four move engine: clears the matrix, alternates players, drops pieces
// into columns and drives single-cycle framebuffer writes upstream of the LED core.
module c4_move_engine
  import c4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_COLS        = BOARD_COLS,
  parameter int NUM_ROWS        = BOARD_ROWS,
  parameter int NUM_LEDS        = MATRIX_LEDS
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] buttons,
  output logic [6:0]          led_num,
  output logic [23:0]         color,
  output logic                write,
  output logic                player,
  output logic                game_over,
  output logic [5:0]          moves
);

  localparam logic [5:0] TOTAL_CELLS = 6'(NUM_COLS * NUM_ROWS);

  logic [NUM_COLS-1:0] press;
  logic                sel_valid;
  logic [2:0]          sel_col;
  logic [6:0]          drop_led;

  state_e      state_q;
  logic [6:0]  clr_q;
  logic [2:0]  col_q;
  logic [2:0]  height_q [NUM_COLS];
  logic        write_q;
  logic [6:0]  led_q;
  logic [23:0] color_q;
  logic        player_q;
  logic        over_q;
  logic [5:0]  moves_q;

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_btn
      c4_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n_i(buttons[gi]),
        .press_o(press[gi])
      );
    end
  endgenerate

  // Scan downwards so the lowest pressed column is the one left selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_col   = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (press[i]) begin
        sel_valid = 1'b1;
        sel_col   = 3'(i);
      end
    end
  end

  // Row 0 of the board maps to matrix row 7 (bottom); all terms stay within 7 bits.
  assign drop_led = (7'd7 - {4'd0, height_q[col_q]}) * 7'd8 + {4'd0, col_q};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= CLEAR;
      clr_q    <= '0;
      col_q    <= '0;
      write_q  <= 1'b0;
      led_q    <= '0;
      color_q  <= C_OFF;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      moves_q  <= '0;
      for (int i = 0; i < NUM_COLS; i++) height_q[i] <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          write_q <= 1'b1;
          led_q   <= clr_q;
          color_q <= C_OFF;
          clr_q   <= clr_q + 7'd1;
          if (clr_q == 7'(NUM_LEDS - 1)) state_q <= IND;
        end
        IND: begin
          write_q <= 1'b1;
          led_q   <= IND_LED;
          color_q <= player_color(player_q);
          if (moves_q == TOTAL_CELLS) begin
            over_q  <= 1'b1;
            state_q <= OVER;
          end else begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          write_q <= 1'b0;
          if (sel_valid && height_q[sel_col] != 3'(NUM_ROWS)) begin
            col_q   <= sel_col;
            state_q <= DROP;
          end
        end
        DROP: begin
          write_q          <= 1'b1;
          led_q            <= drop_led;
          color_q          <= player_color(player_q);
          height_q[col_q]  <= height_q[col_q] + 3'd1;
          moves_q          <= moves_q + 6'd1;
          player_q         <= ~player_q;
          state_q          <= IND;
        end
        OVER: begin
          write_q <= 1'b0;
          over_q  <= 1'b1;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign led_num   = led_q;
  assign color     = color_q;
  assign write     = write_q;
  assign player    = player_q;
  assign game_over = over_q;
  assign moves     = moves_q;

endmodule

// File: tb/tb_c4_move_engine.sv
// Randomised self-checking bench: a board-level game model predicts every
// framebuffer write and the player/moves/game_over outputs.
module tb_c4_move_engine;

  logic        clk_in  = 1'b0;
  logic        rst     = 1'b1;
  logic [5:0]  buttons = 6'h3F;
  logic [6:0]  led_num;
  logic [23:0] color;
  logic        write;
  logic        player;
  logic        game_over;
  logic [5:0]  moves;

  always #5 clk_in = ~clk_in;

  c4_move_engine #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .buttons  (buttons),
    .led_num  (led_num),
    .color    (color),
    .write    (write),
    .player   (player),
    .game_over(game_over),
    .moves    (moves)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed writes and the resulting framebuffer contents (the core's led_reg).
  logic [30:0] wq[$];
  logic [23:0] fb [64];

  always @(negedge clk_in) begin
    if (write === 1'b1) begin
      wq.push_back({led_num, color});
      fb[led_num[5:0]] = color;
    end
  end

  // Game model: column heights, whose turn, move count, and expected writes.
  int          m_h [6];
  int          m_moves;
  bit          m_player;
  bit          m_over;
  logic [30:0] eq[$];

  function automatic logic [23:0] pcol(input bit p);
    return p ? 24'hFFFF00 : 24'hFF0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_h[i] = 0;
    m_moves  = 0;
    m_player = 0;
    m_over   = 0;
    for (int i = 0; i < 64; i++) eq.push_back({7'(i), 24'h000000});
    eq.push_back({7'd63, pcol(0)});
  endtask

  task automatic model_press(input logic [5:0] mask);
    int c;
    if (m_over || mask == 6'd0) return;
    c = 0;
    while (!mask[c]) c++;
    if (m_h[c] >= 6) return;
    eq.push_back({7'((7 - m_h[c]) * 8 + c), pcol(m_player)});
    m_h[c]++;
    m_moves++;
    m_player = !m_player;
    eq.push_back({7'd63, pcol(m_player)});
    if (m_moves == 36) m_over = 1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_val({tag, "_nwr"}, wq.size(), eq.size());
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++) check_val({tag, "_wr"}, {1'b0, wq[i]}, {1'b0, eq[i]});
    $display("txn %s writes=%0d player=%0d moves=%0d game_over=%0d",
             tag, wq.size(), player, moves, game_over);
    wq.delete();
    eq.delete();
    check_val({tag, "_player"}, player, m_player);
    check_val({tag, "_moves"}, moves, m_moves);
    check_val({tag, "_over"}, game_over, m_over);
    check_val({tag, "_ind"}, fb[63], pcol(m_player));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    buttons = 6'h3F;
    @(negedge clk_in);
    check_val({tag, "_rst_write"}, write, 1'b0);
    @(negedge clk_in);
    check_val({tag, "_rst_led"}, led_num, 7'd0);
    check_val({tag, "_rst_color"}, color, 24'd0);
    check_val({tag, "_rst_state"}, {player, game_over, moves}, 8'd0);
    wq.delete();
    eq.delete();
    model_reset();
    rst = 1'b0;
    repeat (70) @(negedge clk_in);
    compare_writes({tag, "_clear"});
  endtask

  task automatic do_press(input string tag, input logic [5:0] mask, input int hold);
    buttons = ~mask;
    repeat (hold) @(negedge clk_in);
    buttons = 6'h3F;
    repeat (12) @(negedge clk_in);
    model_press(mask);
    compare_writes(tag);
  endtask

  task automatic glitch(input string tag, input int btn, input int len);
    buttons[btn] = 1'b0;
    repeat (len) @(negedge clk_in);
    buttons = 6'h3F;
    repeat (10) @(negedge clk_in);
    compare_writes(tag);
  endtask

  initial begin
    int iter;
    int c;
    @(negedge clk_in);
    do_reset("init");

    do_press("btn0_a", 6'b000001, 10);
    do_press("btn0_b", 6'b000001, 10);
    glitch("glitch1", 1, 2);
    do_press("btn0_btn3", 6'b001001, 10);
    for (int i = 0; i < 7; i++) do_press("col2_fill", 6'b000100, 8);

    iter = 0;
    while (!m_over && iter < 600) begin
      iter++;
      if ($urandom_range(0, 4) == 0) glitch("rnd_glitch", $urandom_range(0, 5), $urandom_range(1, 2));
      if ($urandom_range(0, 9) < 2) begin
        do_press("rnd_mask", 6'($urandom_range(1, 63)), $urandom_range(6, 12));
      end else begin
        c = $urandom_range(0, 5);
        while (m_h[c] >= 6) c = (c + 1) % 6;
        do_press("rnd_col", 6'(1 << c), $urandom_range(6, 12));
      end
    end
    check_val("game_over_reached", game_over, 1'b1);
    for (int i = 0; i < 3; i++) do_press("after_over", 6'($urandom_range(1, 63)), 8);

    // Reset landing somewhere inside a press/drop/indicator sequence.
    for (int k = 0; k < 4; k++) begin
      do_reset("pre_mid");
      buttons = 6'b111110;
      repeat ($urandom_range(7, 10)) @(negedge clk_in);
      do_reset("mid_rst");
      do_press("post_rst", 6'b000001, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
